// File: rtl/multiply_divide_unit_pkg.sv
// Shared op-code and state encodings for the multiply/divide unit.
// The op codes are also consumed by the ALU control decoder.
package multiply_divide_unit_pkg;

  localparam logic [3:0] OpMult  = 4'b1000;
  localparam logic [3:0] OpMultu = 4'b1001;
  localparam logic [3:0] OpDiv   = 4'b1010;
  localparam logic [3:0] OpDivu  = 4'b1011;
  localparam logic [3:0] OpMthi  = 4'b0100;
  localparam logic [3:0] OpMtlo  = 4'b0101;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StRun    = 2'd1;
  localparam logic [1:0] StFinish = 2'd2;

  // Multi-cycle ops all live in the 4'b10xx block.
  function automatic logic is_long_op(input logic [3:0] op);
    return op[3:2] == 2'b10;
  endfunction

  function automatic logic is_signed_op(input logic [3:0] op);
    return (op == OpMult) || (op == OpDiv);
  endfunction

endpackage

// File: rtl/multiply_divide_step.sv
// One iteration of the datapath: shift-add for multiply, or restoring
// trial-subtract for divide. Purely combinational.
module multiply_divide_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] upper_i,
  input  logic [WIDTH-1:0] lower_i,
  input  logic [WIDTH-1:0] operand_i,
  output logic [WIDTH-1:0] upper_o,
  output logic [WIDTH-1:0] lower_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             ge;

  always_comb begin
    // Multiply: upper accumulates, lower holds the multiplier being shifted out.
    sum     = {1'b0, upper_i} + (lower_i[0] ? {1'b0, operand_i} : '0);
    // Divide: upper is the partial remainder, lower shifts dividend out / quotient in.
    shifted = {upper_i, lower_i[WIDTH-1]};
    ge      = shifted >= {1'b0, operand_i};
    diff    = shifted[WIDTH-1:0] - operand_i;
    if (is_div_i) begin
      upper_o = ge ? diff : shifted[WIDTH-1:0];
      lower_o = {lower_i[WIDTH-2:0], ge};
    end else begin
      upper_o = sum[WIDTH:1];
      lower_o = {sum[0], lower_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/multiply_divide_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU engine with architectural HI/LO registers.
// Works on magnitudes one bit per cycle and applies sign correction on finish.
module multiply_divide_unit
  import multiply_divide_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [3:0]       control_input,
  input  logic             start_input,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy_output,
  output logic             done_output,
  output logic             divide_by_zero_output,
  output logic [WIDTH-1:0] hi_output,
  output logic [WIDTH-1:0] lo_output
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             neg_lo_q, neg_lo_d;
  logic             neg_hi_q, neg_hi_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] upper_q, upper_d;
  logic [WIDTH-1:0] lower_q, lower_d;
  logic [WIDTH-1:0] operand_q, operand_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH-1:0]   step_upper, step_lower;
  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  multiply_divide_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .is_div_i (is_div_q),
    .upper_i  (upper_q),
    .lower_i  (lower_q),
    .operand_i(operand_q),
    .upper_o  (step_upper),
    .lower_o  (step_lower)
  );

  always_comb begin
    sign_a   = is_signed_op(control_input) & operand_a[WIDTH-1];
    sign_b   = is_signed_op(control_input) & operand_b[WIDTH-1];
    mag_a    = sign_a ? -operand_a : operand_a;
    mag_b    = sign_b ? -operand_b : operand_b;
    prod_fix = neg_lo_q ? -{upper_q, lower_q} : {upper_q, lower_q};
    quot_fix = neg_lo_q ? -lower_q : lower_q;
    // Truncating division: remainder follows the dividend's sign.
    rem_fix  = neg_hi_q ? -upper_q : upper_q;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_lo_d  = neg_lo_q;
    neg_hi_d  = neg_hi_q;
    zero_d    = zero_q;
    upper_d   = upper_q;
    lower_d   = lower_q;
    operand_d = operand_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dbz_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_input) begin
          if (is_long_op(control_input)) begin
            is_div_d = control_input[1];
            neg_lo_d = sign_a ^ sign_b;
            neg_hi_d = sign_a;
            upper_d  = '0;
            cnt_d    = '0;
            if (control_input[1]) begin
              lower_d   = mag_a;
              operand_d = mag_b;
            end else begin
              lower_d   = mag_b;
              operand_d = mag_a;
            end
            zero_d  = control_input[1] && (operand_b == '0);
            state_d = (control_input[1] && (operand_b == '0)) ? StFinish : StRun;
          end else if (control_input == OpMthi) begin
            hi_d = operand_a;
          end else if (control_input == OpMtlo) begin
            lo_d = operand_a;
          end
        end
      end
      StRun: begin
        upper_d = step_upper;
        lower_d = step_lower;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          state_d = StFinish;
        end
      end
      StFinish: begin
        state_d = StIdle;
        done_d  = 1'b1;
        dbz_d   = zero_q;
        if (!zero_q) begin
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quot_fix;
          end else begin
            {hi_d, lo_d} = prod_fix;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_lo_q  <= 1'b0;
      neg_hi_q  <= 1'b0;
      zero_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
      upper_q   <= '0;
      lower_q   <= '0;
      operand_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_lo_q  <= neg_lo_d;
      neg_hi_q  <= neg_hi_d;
      zero_q    <= zero_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
      upper_q   <= upper_d;
      lower_q   <= lower_d;
      operand_q <= operand_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy_output           = state_q != StIdle;
  assign done_output           = done_q;
  assign divide_by_zero_output = dbz_q;
  assign hi_output             = hi_q;
  assign lo_output             = lo_q;

endmodule

// File: tb/tb_multiply_divide_unit.sv
// Scoreboard bench for multiply_divide_unit: directed corner cases plus
// randomized ops checked against a plain-arithmetic reference model.
module tb_multiply_divide_unit;

  localparam logic [3:0] CMult  = 4'b1000;
  localparam logic [3:0] CMultu = 4'b1001;
  localparam logic [3:0] CDiv   = 4'b1010;
  localparam logic [3:0] CDivu  = 4'b1011;
  localparam logic [3:0] CMthi  = 4'b0100;
  localparam logic [3:0] CMtlo  = 4'b0101;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  control_input = '0;
  logic        start_input = 1'b0;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic        busy_output, done_output, divide_by_zero_output;
  logic [31:0] hi_output, lo_output;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;
  int          n_checks = 0;
  int          n_fail = 0;

  multiply_divide_unit #(
    .WIDTH(32)
  ) dut (
    .clock                (clock),
    .reset                (reset),
    .control_input        (control_input),
    .start_input          (start_input),
    .operand_a            (operand_a),
    .operand_b            (operand_b),
    .busy_output          (busy_output),
    .done_output          (done_output),
    .divide_by_zero_output(divide_by_zero_output),
    .hi_output            (hi_output),
    .lo_output            (lo_output)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: MIPS semantics straight from integer arithmetic.
  task automatic model_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint sa, sb, q, r;
    longint unsigned p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.dbz = 1'b0;
    case (c)
      CMult: begin
        p = longint'(sa * sb);
        {e.hi, e.lo} = p;
      end
      CMultu: begin
        p = {32'b0, a} * {32'b0, b};
        {e.hi, e.lo} = p;
      end
      CDiv, CDivu: begin
        if (b == 0) begin
          e.dbz = 1'b1;
          e.hi  = model_hi;
          e.lo  = model_lo;
        end else if (c == CDiv) begin
          q = sa / sb;
          r = sa % sb;
          e.lo = q[31:0];
          e.hi = r[31:0];
        end else begin
          e.lo = a / b;
          e.hi = a % b;
        end
      end
      default: e = '{hi: model_hi, lo: model_lo, dbz: 1'b0};
    endcase
    if (c == CMthi) model_hi = a;
    else if (c == CMtlo) model_lo = a;
    else if (c[3:2] == 2'b10) begin
      model_hi = e.hi;
      model_lo = e.lo;
      exp_q.push_back(e);
    end
  endtask

  // Drives one start pulse; caller guarantees the DUT is idle at the next edge.
  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    control_input = c;
    operand_a     = a;
    operand_b     = b;
    start_input   = 1'b1;
    @(posedge clock);
    #1;
    start_input = 1'b0;
    model_op(c, a, b);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy_output && n < 100) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (busy_output) check("wait_idle_timeout", 64'(busy_output), 64'd0);
  endtask

  task automatic timed_op(input string name, input logic [3:0] c, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat, input int exp_busy);
    int lat, busy_cnt;
    wait_idle();
    issue(c, a, b);
    busy_cnt = int'(busy_output);
    lat = 0;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clock);
      #1;
      if (done_output) begin
        lat = n;
        break;
      end
      busy_cnt += int'(busy_output);
    end
    check({name, "_latency"}, 64'(lat), 64'(exp_lat));
    check({name, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_busy));
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (!reset) begin
      if (divide_by_zero_output && !done_output)
        check("dbz_without_done", 64'(divide_by_zero_output), 64'd0);
      if (done_output) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'(done_output), 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("result_hi", 64'(hi_output), 64'(e.hi));
          check("result_lo", 64'(lo_output), 64'(e.lo));
          check("result_dbz", 64'(divide_by_zero_output), 64'(e.dbz));
        end
      end
    end
  end

  initial begin
    logic [3:0]  ops[6];
    logic [31:0] specials[6];
    logic [31:0] ra, rb;
    int          n;
    ops      = '{CMult, CMultu, CDiv, CDivu, CMthi, CMtlo};
    specials = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1, 32'h3};

    #12;
    check("reset_busy", 64'(busy_output), 64'd0);
    check("reset_done", 64'(done_output), 64'd0);
    check("reset_dbz", 64'(divide_by_zero_output), 64'd0);
    check("reset_hi", 64'(hi_output), 64'd0);
    check("reset_lo", 64'(lo_output), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;

    timed_op("multu_max", CMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 33);
    wait_idle(); issue(CMult, 32'hFFFF_FFFD, 32'd7);
    wait_idle(); issue(CDiv, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(); issue(CDivu, 32'd100, 32'd7);
    wait_idle(); issue(CDiv, 32'hFFFF_FFF9, 32'd2);

    wait_idle(); issue(CMthi, 32'h1234, 32'h0);
    check("mthi_hi", 64'(hi_output), 64'h1234);
    check("mthi_no_busy", 64'(busy_output), 64'd0);
    issue(CMtlo, 32'h5678, 32'h0);
    check("mtlo_lo", 64'(lo_output), 64'h5678);
    timed_op("div_by_zero", CDiv, 32'd5, 32'd0, 1, 1);
    check("dbz_hi_kept", 64'(hi_output), 64'h1234);
    check("dbz_lo_kept", 64'(lo_output), 64'h5678);

    // Reset in the middle of an operation.
    wait_idle(); issue(CMultu, 32'd3, 32'd4);
    repeat (10) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("abort_busy", 64'(busy_output), 64'd0);
    check("abort_hi", 64'(hi_output), 64'd0);
    check("abort_lo", 64'(lo_output), 64'd0);
    exp_q.delete();
    model_hi = '0;
    model_lo = '0;
    @(negedge clock);
    reset = 1'b0;
    repeat (40) @(posedge clock);
    #1;
    issue(CMultu, 32'd3, 32'd4);
    wait_idle();
    @(posedge clock);
    #1;
    check("after_abort_lo", 64'(lo_output), 64'd12);

    // Starts and moves while busy are ignored; restart in the done cycle is taken.
    issue(CMultu, 32'h1111, 32'h22);
    repeat (3) @(posedge clock);
    #1;
    control_input = CDivu; operand_a = 32'd9; operand_b = 32'd3; start_input = 1'b1;
    @(posedge clock);
    #1;
    control_input = CMtlo; operand_a = 32'hDEAD;
    @(posedge clock);
    #1;
    start_input = 1'b0;
    n = 0;
    while (!done_output && n < 100) begin
      @(posedge clock);
      #1;
      n++;
    end
    check("busy_ignore_done_seen", 64'(done_output), 64'd1);
    issue(CMult, 32'hFFFF_FF00, 32'h0000_0100);
    check("back_to_back_busy", 64'(busy_output), 64'd1);

    for (int i = 0; i < 60; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 2) == 0) rb = rb & 32'hFF;
      wait_idle();
      issue(ops[$urandom_range(0, 5)], ra, rb);
    end

    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clock);
      n++;
    end
    check("drain_outstanding", 64'(exp_q.size()), 64'd0);
    repeat (3) @(posedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
